// File: rtl/decoder.sv
`default_nettype none
// ============================================================================
// Module   : decoder
// Purpose  : In-order fetch/decode/issue stage feeding the reorder buffer.
//            Fetches one instruction at a time, decodes RV32I fields and
//            issues them with a static next-PC prediction. Stalls on ROB
//            full, JALR resolution and EXIT; redirects on ROB flush.
// Options  : DECODER_BTFN_EN - predict backward branches taken.
// Revision : 1.0 - initial release
// ============================================================================
module decoder #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          REG_ID_BIT = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  fetch_req,
  output logic [31:0]           fetch_pc,
  input  logic                  inst_valid,
  input  logic [31:0]           inst_data,
  input  logic                  rob_full,
  output logic                  to_rob,
  output logic [5:0]            op_type,
  output logic [REG_ID_BIT-1:0] rd,
  output logic [REG_ID_BIT-1:0] rs1,
  output logic [REG_ID_BIT-1:0] rs2,
  output logic [31:0]           imm,
  output logic [31:0]           inst_pc,
  output logic [31:0]           pc,
  input  logic                  jalr_resolved,
  input  logic [31:0]           jalr_target,
  input  logic                  rob_flush,
  input  logic [31:0]           flush_pc
);

  localparam logic [5:0]  c_op_lui     = 6'd0;
  localparam logic [5:0]  c_op_auipc   = 6'd1;
  localparam logic [5:0]  c_op_jal     = 6'd2;
  localparam logic [5:0]  c_op_jalr    = 6'd3;
  localparam logic [5:0]  c_op_beq     = 6'd4;
  localparam logic [5:0]  c_op_bgeu    = 6'd9;
  localparam logic [5:0]  c_op_lb      = 6'd10;
  localparam logic [5:0]  c_op_sb      = 6'd15;
  localparam logic [5:0]  c_op_addi    = 6'd18;
  localparam logic [5:0]  c_op_add     = 6'd27;
  localparam logic [5:0]  c_op_illegal = 6'd38;
  localparam logic [5:0]  c_op_exit    = 6'd39;
  localparam logic [31:0] c_exit_word  = 32'h0ff00513;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT      = 3'd1,
    S_HOLD      = 3'd2,
    S_JALR_WAIT = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_cnt;
  logic        r_discard;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;

  logic [31:0]           w_word;
  logic [31:0]           w_ipc;
  logic [5:0]            w_op;
  logic [REG_ID_BIT-1:0] w_rd;
  logic [REG_ID_BIT-1:0] w_rs1;
  logic [REG_ID_BIT-1:0] w_rs2;
  logic [31:0]           w_imm;
  logic [31:0]           w_npc;
  logic                  w_issue;
  logic [2:0]            w_f3;
  logic [6:0]            w_f7;

  // Decode either the word arriving now or the word parked in HOLD
  always_comb begin
    w_word = (r_state == S_WAIT) ? inst_data : r_inst;
    w_ipc  = (r_state == S_WAIT) ? fetch_pc  : r_inst_pc;
    w_f3   = w_word[14:12];
    w_f7   = w_word[31:25];
    w_op   = c_op_illegal;
    w_rd   = REG_ID_BIT'(w_word[11:7]);
    w_rs1  = REG_ID_BIT'(w_word[19:15]);
    w_rs2  = REG_ID_BIT'(w_word[24:20]);
    w_imm  = {{20{w_word[31]}}, w_word[31:20]};
    case (w_word[6:0])
      7'b0110111, 7'b0010111: begin
        w_op  = (w_word[5]) ? c_op_lui : c_op_auipc;
        w_rs1 = '0;
        w_rs2 = '0;
        w_imm = {w_word[31:12], 12'h000};
      end
      7'b1101111: begin
        w_op  = c_op_jal;
        w_rs1 = '0;
        w_rs2 = '0;
        w_imm = {{12{w_word[31]}}, w_word[19:12], w_word[20], w_word[30:21], 1'b0};
      end
      7'b1100111: begin
        if (w_f3 == 3'b000) w_op = c_op_jalr;
        w_rs2 = '0;
      end
      7'b1100011: begin
        // BEQ,BNE,-,-,BLT,BGE,BLTU,BGEU -> 4..9
        if (w_f3 == 3'b000 || w_f3 == 3'b001) w_op = c_op_beq + {5'd0, w_f3[0]};
        else if (w_f3[2])                     w_op = c_op_beq + {4'd0, w_f3[1:0]} + 6'd2;
        w_rd  = '0;
        w_imm = {{20{w_word[31]}}, w_word[7], w_word[30:25], w_word[11:8], 1'b0};
      end
      7'b0000011: begin
        // LB,LH,LW,-,LBU,LHU -> 10..14
        if (w_f3 <= 3'b010)                     w_op = c_op_lb + {3'd0, w_f3};
        else if (w_f3 == 3'b100 || w_f3 == 3'b101) w_op = c_op_lb + {3'd0, w_f3} - 6'd1;
        w_rs2 = '0;
      end
      7'b0100011: begin
        if (w_f3 <= 3'b010) w_op = c_op_sb + {3'd0, w_f3};
        w_rd  = '0;
        w_imm = {{20{w_word[31]}}, w_word[31:25], w_word[11:7]};
      end
      7'b0010011: begin
        w_rs2 = '0;
        case (w_f3)
          3'b000: w_op = c_op_addi;
          3'b010: w_op = c_op_addi + 6'd1;
          3'b011: w_op = c_op_addi + 6'd2;
          3'b100: w_op = c_op_addi + 6'd3;
          3'b110: w_op = c_op_addi + 6'd4;
          3'b111: w_op = c_op_addi + 6'd5;
          3'b001: if (w_f7 == 7'b0000000) w_op = c_op_addi + 6'd6;
          3'b101: begin
            if (w_f7 == 7'b0000000)      w_op = c_op_addi + 6'd7;
            else if (w_f7 == 7'b0100000) w_op = c_op_addi + 6'd8;
          end
          default: w_op = c_op_illegal;
        endcase
        // Shift amounts are unsigned and exclude the funct7 bits
        if (w_f3 == 3'b001 || w_f3 == 3'b101) w_imm = {27'd0, w_word[24:20]};
      end
      7'b0110011: begin
        w_imm = '0;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_op = c_op_add;
            3'b001:  w_op = c_op_add + 6'd2;
            3'b010:  w_op = c_op_add + 6'd3;
            3'b011:  w_op = c_op_add + 6'd4;
            3'b100:  w_op = c_op_add + 6'd5;
            3'b101:  w_op = c_op_add + 6'd6;
            3'b110:  w_op = c_op_add + 6'd8;
            default: w_op = c_op_add + 6'd9;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      w_op = c_op_add + 6'd1;
          else if (w_f3 == 3'b101) w_op = c_op_add + 6'd7;
        end
      end
      default: w_op = c_op_illegal;
    endcase
    if (w_op == c_op_illegal) begin
      w_rd  = '0;
      w_rs1 = '0;
      w_rs2 = '0;
      w_imm = '0;
    end
    // The halt marker keeps its ADDI operand fields but reports EXIT
    if (w_word == c_exit_word) w_op = c_op_exit;
  end

  // Static next-PC prediction and issue qualification
  always_comb begin
    w_npc = w_ipc + 32'd4;
    if (w_op == c_op_jal) w_npc = w_ipc + w_imm;
`ifdef DECODER_BTFN_EN
    if (w_op >= c_op_beq && w_op <= c_op_bgeu && w_imm[31]) w_npc = w_ipc + w_imm;
`endif
    w_issue = !rob_flush && !rob_full &&
              (((r_state == S_WAIT) && inst_valid) || (r_state == S_HOLD));
  end

  // Fetch/issue FSM with registered outputs; flush overrides everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_fetch_cnt <= RESET_PC;
      r_discard   <= 1'b0;
      r_inst      <= '0;
      r_inst_pc   <= '0;
      fetch_req   <= 1'b0;
      fetch_pc    <= RESET_PC;
      to_rob      <= 1'b0;
      op_type     <= '0;
      rd          <= '0;
      rs1         <= '0;
      rs2         <= '0;
      imm         <= '0;
      inst_pc     <= '0;
      pc          <= '0;
    end else if (rdy_in) begin
      fetch_req <= 1'b0;
      to_rob    <= 1'b0;
      if (rob_flush) begin
        r_fetch_cnt <= flush_pc;
        r_state     <= S_IDLE;
        // A request still in flight after this cycle must have its reply dropped
        r_discard   <= ((r_state == S_WAIT) || r_discard) && !inst_valid;
      end else begin
        if (r_discard && inst_valid) r_discard <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (!r_discard) begin
              fetch_req <= 1'b1;
              fetch_pc  <= r_fetch_cnt;
              r_state   <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (inst_valid) begin
              r_inst    <= inst_data;
              r_inst_pc <= fetch_pc;
              if (rob_full) r_state <= S_HOLD;
            end
          end
          S_JALR_WAIT: begin
            if (jalr_resolved) begin
              r_fetch_cnt <= jalr_target;
              r_state     <= S_IDLE;
            end
          end
          S_HOLD, S_HALT: r_state <= r_state;
          default: r_state <= S_IDLE;
        endcase
        if (w_issue) begin
          to_rob  <= 1'b1;
          op_type <= w_op;
          rd      <= w_rd;
          rs1     <= w_rs1;
          rs2     <= w_rs2;
          imm     <= w_imm;
          inst_pc <= w_ipc;
          pc      <= w_npc;
          if (w_op == c_op_jalr)      r_state <= S_JALR_WAIT;
          else if (w_op == c_op_exit) r_state <= S_HALT;
          else begin
            r_fetch_cnt <= w_npc;
            r_state     <= S_IDLE;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/decoder.md
# decoder

In-order fetch/decode/issue stage sitting directly upstream of the reorder buffer. Requests one instruction at a time from the instruction memory interface and decodes it into op_type/rd/rs1/rs2/imm. Issues each instruction to the ROB with a one-cycle `to_rob` pulse, applying a static next-PC prediction. Stalls on ROB full, JALR resolution and exit, and redirects on ROB flush.

## Interface
- `RESET_PC`, default 32'h0: fetch address after reset.
- `REG_ID_BIT`, default 5: register index width (matches `` `REG_ID_BIT ``).

Ports:
- `clk_in`  in  1  clock; all state on rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `rdy_in`  in  1  pause when low; all state frozen.
- `fetch_req`  out  1  one-cycle request pulse.
- `fetch_pc`  out  32  address of the requested instruction; held until next request.
- `inst_valid`  in  1  one-cycle response pulse for the outstanding request.
- `inst_data`  in  32  instruction word, valid with `inst_valid`.
- `rob_full`  in  1  ROB cannot accept an entry this cycle.
- `to_rob`  out  1  one-cycle issue pulse.
- `op_type`  out  6  decoded operation.
- `rd`, `rs1`, `rs2`  out  REG_ID_BIT  register indices; 0 when unused.
- `imm`  out  32  decoded immediate.
- `inst_pc`  out  32  address of the issued instruction.
- `pc`  out  32  predicted next PC.
- `jalr_resolved`  in  1  ROB has computed the JALR target.
- `jalr_target`  in  32  JALR target, valid with `jalr_resolved`.
- `rob_flush`  in  1  mispredict/redirect.
- `flush_pc`  in  32  redirect address, valid with `rob_flush`.

## Operation
op_type encoding:
- LUI 0, AUIPC 1, JAL 2, JALR 3.
- BEQ..BGEU 4–9.
- LB, LH, LW, LBU, LHU 10–14.
- SB, SH, SW 15–17.
- ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI 18–26.
- ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND 27–36.
- ILLEGAL 38.
- EXIT 39: the exact word 32'h0ff00513. This takes priority over ADDI.

Immediates:
- I/S/B/J: sign-extended per RV32I format.
- Shifts: shamt zero-extended.
- LUI/AUIPC: `inst[31:12]<<12`.
- R-type: imm 0.

FSM states:
- IDLE: pulse `fetch_req` with `fetch_pc`=fetch counter, then go to WAIT.
- WAIT: on `inst_valid`, latch and decode the word.
  - If `rob_full`=0, issue and go to the next state.
  - Otherwise go to HOLD.
- HOLD: issue in the first cycle `rob_full`=0.
- After issue:
  - JALR: go to JALR_WAIT.
  - EXIT: go to HALT.
  - Otherwise: go to IDLE with fetch counter = `pc`.
- JALR_WAIT: on `jalr_resolved`, set fetch counter = `jalr_target` and go to IDLE.
- HALT: no further fetches. Left only by flush or reset.

Next-PC prediction (`pc`):
- JAL: `inst_pc+imm`.
- Branches: see Configuration.
- All others, including JALR and EXIT: `inst_pc+4`.
- All PC arithmetic is 32-bit wrap-around.

Flush:
- `rob_flush` takes priority in every state, including over same-cycle `inst_valid`, `jalr_resolved` and issue.
- Fetch counter is set to `flush_pc` and the held instruction is dropped.
- Next state is IDLE.
- If a request is outstanding, a discard flag is set. The next `inst_valid` is ignored and clears the flag; IDLE does not request until the flag is clear.

Pause: with `rdy_in`=0, no state, output or flag changes. Outputs hold their last values; the ROB pauses on the same signal.

## Timing
- Reset values: all outputs 0, except `fetch_pc`=RESET_PC. State IDLE, fetch counter RESET_PC, discard flag 0.
- Reset asserted mid-operation clears everything immediately. The memory interface shares `rst_in`.
- `fetch_req` fires the cycle after entering IDLE (including the first cycle after reset release).
- Issue latency: `inst_valid` sampled at edge t with `rob_full`=0 produces `to_rob`=1 for cycle t+1 only, all decode outputs registered alongside.
- `fetch_req` for the next instruction is asserted in cycle t+2. Throughput is 1 instruction per (memory latency + 2) cycles.
- HOLD: `to_rob` rises the cycle after `rob_full` is sampled low.
- Issue outputs other than `to_rob` hold their values until the next issue.

## Configuration
- `DECODER_BTFN_EN` defined: branches with negative imm (`imm[31]`=1) get `pc`=`inst_pc+imm`. Forward branches get `inst_pc+4`.
- Undefined: all branches are predicted not-taken, `pc`=`inst_pc+4`.

## Test plan
- Reset release, memory returns 32'h00500093 (addi x1,x0,5) at addr 0 → `fetch_req` with `fetch_pc`=0; one cycle after `inst_valid`: `to_rob`=1, op 18, rd 1, rs1 0, imm 5, `inst_pc` 0, `pc` 4.
- `rob_full`=1 for 3 cycles when a word arrives → no `to_rob` while full; single `to_rob` pulse the cycle after `rob_full` falls; no fetch before it.
- JALR (32'h000080e7) issued → state JALR_WAIT, no `fetch_req`; `jalr_resolved` with target 32'h100 → next `fetch_pc`=32'h100.
- Backward BEQ at 32'h20, imm −8 → `pc`=32'h18 with `DECODER_BTFN_EN` defined, 32'h24 without.
- `rob_flush` with `flush_pc`=32'h40 while a request is outstanding → the next response is discarded (no `to_rob`); next `fetch_pc`=32'h40.
- Word 32'h0ff00513 → op 39 issued, no further `fetch_req` for 20 cycles; `rob_flush` to 32'h8 resumes fetching at 32'h8.
